// File: rtl/freq_mem_sched_pkg.sv
// rtl/freq_mem_sched_pkg.sv - shared sizes and state encoding for the frequency memory scheduler
package freq_mem_sched_pkg;

  localparam int NSYM_D = 286;
  localparam int AW_D   = 9;
  localparam int CW_D   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_READ  = 3'd4
  } state_t;

endpackage

// File: rtl/freq_rd_skid.sv
// rtl/freq_rd_skid.sv - one-entry skid buffer with bypass for the count readout path
// o_issue_ok is a credit: a read issued now lands next cycle and is guaranteed a slot.
module freq_rd_skid #(
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_s_tvalid,
  input  logic [DW-1:0] i_s_tdata,
  output logic          o_issue_ok,
  output logic          o_m_tvalid,
  output logic [DW-1:0] o_m_tdata,
  input  logic          i_m_tready
);

  logic          r_full;
  logic [DW-1:0] r_data;
  logic          w_full_nxt;

  // Arriving data goes straight out when the skid is empty, else it queues behind it.
  assign w_full_nxt = i_s_tvalid ? (r_full || !i_m_tready) : (r_full && !i_m_tready);
  assign o_issue_ok = !w_full_nxt;
  assign o_m_tvalid = r_full || i_s_tvalid;
  assign o_m_tdata  = r_full ? r_data : (i_s_tvalid ? i_s_tdata : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (i_s_tvalid && (r_full || !i_m_tready))
        r_data <= i_s_tdata;
    end
  end

endmodule

// File: rtl/freq_mem_sched.sv
// rtl/freq_mem_sched.sv - literal/length frequency memory scheduler: clear, count, readout
module freq_mem_sched
  import freq_mem_sched_pkg::*;
#(
  parameter int NSYM = NSYM_D,
  parameter int AW   = AW_D,
  parameter int CW   = CW_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic          rd_req,
  input  logic          sym_valid,
  input  logic [AW-1:0] sym,
  input  logic          sym_last,
  output logic          sym_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sym,
  output logic [CW-1:0] out_cnt,
  output logic          busy,
  output logic          done,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [CW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [CW-1:0] mem_wdata
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NSYM - 1);
  localparam logic [AW-1:0] END_ADDR  = AW'(NSYM);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic             r_s2_valid;
  logic [AW-1:0]    r_s2_addr;
  logic             r_fwd_valid;
  logic [AW-1:0]    r_fwd_addr;
  logic [CW-1:0]    r_fwd_data;
  logic             r_pend;
  logic [AW-1:0]    r_pend_sym;
  logic             r_rd_fin;
  logic             w_sym_acc;
  logic             w_s1_fire;
  logic             w_clr_we;
  logic             w_rd_issue;
  logic             w_issue_ok;
  logic             w_s2_hit;
  logic [CW-1:0]    w_s2_cnt;
  logic [CW-1:0]    w_s2_inc;
  logic [AW+CW-1:0] w_out_data;

  assign w_sym_acc  = sym_valid && sym_ready;
  assign w_s1_fire  = w_sym_acc && (sym < END_ADDR);
  assign w_clr_we   = (r_state == ST_CLEAR) && (r_addr != END_ADDR);
  assign w_rd_issue = (r_state == ST_READ) && (r_addr != END_ADDR) && w_issue_ok;

  // Memory returns old data on a same-cycle read/write, so a distance-1 repeat needs the forward.
  assign w_s2_hit = r_fwd_valid && (r_fwd_addr == r_s2_addr);
  assign w_s2_cnt = w_s2_hit ? r_fwd_data : mem_rdata;
  assign w_s2_inc = (w_s2_cnt == CNT_MAX) ? CNT_MAX : w_s2_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_req)        w_state_nxt = ST_CLEAR;
        else if (rd_req)    w_state_nxt = ST_READ;
        else if (w_sym_acc) w_state_nxt = sym_last ? ST_FLUSH : ST_COUNT;
      end
      ST_CLEAR: if (r_addr == END_ADDR)    w_state_nxt = ST_IDLE;
      ST_COUNT: if (w_sym_acc && sym_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_IDLE;
      ST_READ:  if (r_rd_fin)              w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Requests win over symbols in IDLE, so a symbol is never handshaken while a request is taken.
  always_comb begin
    sym_ready = ((r_state == ST_IDLE) && !clr_req && !rd_req) || (r_state == ST_COUNT);
    busy      = (r_state != ST_IDLE);
    done      = ((r_state == ST_CLEAR) && (r_addr == END_ADDR)) ||
                (r_state == ST_FLUSH) ||
                ((r_state == ST_READ) && r_rd_fin);
    mem_re    = w_s1_fire || w_rd_issue;
    mem_raddr = '0;
    if (w_rd_issue)     mem_raddr = r_addr;
    else if (w_s1_fire) mem_raddr = sym;
    mem_we    = w_clr_we || r_s2_valid;
    mem_waddr = '0;
    mem_wdata = '0;
    if (w_clr_we) begin
      mem_waddr = r_addr;
    end else if (r_s2_valid) begin
      mem_waddr = r_s2_addr;
      mem_wdata = w_s2_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_addr   <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_pend      <= 1'b0;
      r_pend_sym  <= '0;
      r_rd_fin    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE)          r_addr <= '0;
      else if (w_clr_we || w_rd_issue) r_addr <= r_addr + 1'b1;
      r_s2_valid  <= w_s1_fire;
      r_s2_addr   <= sym;
      r_fwd_valid <= mem_we;
      r_fwd_addr  <= mem_waddr;
      r_fwd_data  <= mem_wdata;
      r_pend      <= w_rd_issue;
      r_pend_sym  <= r_addr;
      r_rd_fin    <= (r_state == ST_READ) && out_valid && out_ready && (out_sym == LAST_ADDR);
    end
  end

  freq_rd_skid #(
    .DW(AW + CW)
  ) u_rd_skid (
    .clk        (clk),
    .rst_n      (reset),
    .i_s_tvalid (r_pend),
    .i_s_tdata  ({r_pend_sym, mem_rdata}),
    .o_issue_ok (w_issue_ok),
    .o_m_tvalid (out_valid),
    .o_m_tdata  (w_out_data),
    .i_m_tready (out_ready)
  );

  assign {out_sym, out_cnt} = w_out_data;

endmodule

// File: tb/tb_freq_mem_sched.sv
// tb/tb_freq_mem_sched.sv - directed self-checking bench for freq_mem_sched with a 4-bit count
module tb_freq_mem_sched;
  localparam int NSYM = 286;
  localparam int AW   = 9;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr_req, rd_req, sym_valid, sym_last, out_ready;
  logic [AW-1:0] sym;
  logic          sym_ready, out_valid, busy, done, mem_re, mem_we;
  logic [AW-1:0] out_sym, mem_raddr, mem_waddr;
  logic [CW-1:0] out_cnt, mem_rdata, mem_wdata;

  logic [CW-1:0] mem [0:NSYM-1];
  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt [NSYM];
  int prev_s;

  always #5 clk = ~clk;

  freq_mem_sched #(.NSYM(NSYM), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .rd_req(rd_req),
    .sym_valid(sym_valid), .sym(sym), .sym_last(sym_last), .sym_ready(sym_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_cnt(out_cnt),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Single-port-pair memory: one-cycle read latency, old data on same-address read/write.
  always @(posedge clk) begin
    if (mem_we && mem_waddr < NSYM) mem[mem_waddr] <= mem_wdata;
    if (mem_re && mem_raddr < NSYM) mem_rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_sym_ready"}, sym_ready, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_sym"}, out_sym, 0);
    chk({pfx, "_out_cnt"}, out_cnt, 0);
    chk({pfx, "_mem_re"}, mem_re, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
  endtask

  task automatic run_clear();
    int  nw;
    int  cyc;
    bit  seen;
    tick(); clr_req = 1'b1; neg();
    chk("clr_idle_busy", busy, 0);
    tick(); clr_req = 1'b0; neg();
    chk("clr_first_we", mem_we, 1);
    chk("clr_first_addr", mem_waddr, 0);
    chk("clr_busy", busy, 1);
    chk("clr_sym_ready", sym_ready, 0);
    nw = 1; seen = 1'b0; cyc = 0;
    while (cyc < 400 && !seen) begin
      tick(); neg(); cyc++;
      if (mem_we) nw++;
      if (done) seen = 1'b1;
    end
    chk("clr_done_seen", seen, 1);
    chk("clr_writes", nw, NSYM);
    chk("clr_done_cycle", cyc, NSYM);
    for (int i = 0; i < NSYM; i++) exp_cnt[i] = 0;
    tick(); neg();
    chk("clr_idle_after", busy, 0);
  endtask

  task automatic run_read(input bit rnd, input bit lat);
    int idx;
    int iters;
    bit seen;
    bit prev_stall;
    int p_sym;
    int p_cnt;
    tick(); rd_req = 1'b1; out_ready = 1'b1; neg();
    tick(); rd_req = 1'b0; if (rnd) out_ready = 1'($urandom_range(0, 1)); neg();
    if (lat) begin
      chk("rd_lat_re", mem_re, 1);
      chk("rd_lat_addr", mem_raddr, 0);
      chk("rd_lat_ov0", out_valid, 0);
    end
    idx = 0; seen = 1'b0; prev_stall = 1'b0; p_sym = 0; p_cnt = 0; iters = 0;
    while (iters < 3000 && !seen) begin
      tick(); if (rnd) out_ready = 1'($urandom_range(0, 1)); neg();
      if (lat && iters == 0) chk("rd_lat_ov1", out_valid, 1);
      iters++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sym", out_sym, p_sym);
        chk("stall_cnt", out_cnt, p_cnt);
      end
      if (done) seen = 1'b1;
      else if (out_valid && out_ready) begin
        chk("rd_sym", out_sym, idx);
        chk("rd_cnt", out_cnt, (idx < NSYM) ? exp_cnt[idx] : -1);
        idx++;
      end
      prev_stall = out_valid && !out_ready;
      p_sym = out_sym;
      p_cnt = out_cnt;
    end
    chk("rd_done_seen", seen, 1);
    chk("rd_entries", idx, NSYM);
    out_ready = 1'b0;
    tick(); neg();
    chk("rd_idle_after", busy, 0);
  endtask

  task automatic send(input int s, input bit last);
    tick(); sym_valid = 1'b1; sym = s[AW-1:0]; sym_last = last; neg();
    chk("sym_ready", sym_ready, 1);
    chk("s1_re", mem_re, (s < NSYM) ? 1 : 0);
    if (s < NSYM) chk("s1_raddr", mem_raddr, s);
    if (prev_s < 0) chk("s2_idle_we", mem_we, 0);
    else            chk("s2_we", mem_we, (prev_s < NSYM) ? 1 : 0);
    if (s < NSYM && exp_cnt[s] < CMAX) exp_cnt[s]++;
    prev_s = s;
  endtask

  task automatic finish_block();
    tick(); sym_valid = 1'b0; sym_last = 1'b0; sym = '0; neg();
    chk("flush_done", done, 1);
    chk("flush_we", mem_we, (prev_s < NSYM) ? 1 : 0);
    tick(); neg();
    chk("flush_idle", busy, 0);
    chk("flush_done_low", done, 0);
    prev_s = -1;
  endtask

  initial begin
    reset = 1'b0; clr_req = 1'b0; rd_req = 1'b0; sym_valid = 1'b0;
    sym_last = 1'b0; sym = '0; out_ready = 1'b0; prev_s = -1;
    for (int i = 0; i < NSYM; i++) exp_cnt[i] = 0;
    repeat (3) tick();
    neg();
    chk_reset_vals("rst_hold");
    tick(); reset = 1'b1; neg();
    chk_reset_vals("rst_rel");

    run_clear();
    run_read(1'b0, 1'b1);

    run_clear();
    send(5, 0); send(5, 0); send(5, 0); send(7, 0); send(5, 1);
    finish_block();
    chk("model_cnt5", exp_cnt[5], 4);
    run_read(1'b0, 1'b0);

    run_clear();
    send(10, 0); send(11, 0); send(10, 0); send(300, 0); send(20, 0); send(20, 1);
    finish_block();
    send(100, 1);
    finish_block();
    for (int i = 0; i < 20; i++) send(3, (i == 19));
    finish_block();
    run_read(1'b1, 1'b0);

    send(40, 0); send(41, 0);
    tick(); reset = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym = '0; neg();
    chk_reset_vals("rst_count");
    tick(); reset = 1'b1; neg();
    chk_reset_vals("rst_count_rel");
    prev_s = -1;
    run_clear();
    send(1, 1);
    finish_block();
    run_read(1'b0, 1'b0);

    tick(); rd_req = 1'b1; out_ready = 1'b1; neg();
    tick(); rd_req = 1'b0; neg();
    repeat (10) begin tick(); neg(); end
    chk("mid_read_valid", out_valid, 1);
    tick(); reset = 1'b0; neg();
    chk_reset_vals("rst_read");
    tick(); reset = 1'b1; out_ready = 1'b0; neg();
    chk_reset_vals("rst_read_rel");
    run_clear();
    send(284, 0); send(285, 1);
    finish_block();
    run_read(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
